// File: rtl/snake_body_stream_if.sv
// -----------------------------------------------------------------------------
// snake_body_stream_if
// Bundles the game-control inputs and the segment-stream outputs of
// snake_body_stream. The game logic / bench side uses the master modport,
// the snake block uses the slave modport.
//
// Signals (direction seen from the slave):
//   game_rst      in   re-init snake state
//   move          in   one-cycle move pulse
//   move_dir      in   requested heading (0=+x, 1=-x, 2=+y, 3=-y)
//   grow          in   grow on this move
//   scan_start    in   one-cycle pulse, stream the body
//   snake_head_x  out  head column
//   snake_head_y  out  head row
//   snake_x/y     out  streamed segment coordinate
//   snake_dir     out  direction toward the next (tail-ward) segment
//   snake_first   out  streamed segment is the head
//   snake_last    out  streamed segment is the tail
//   snake_valid   out  stream fields valid
//   length        out  segment count
//   full          out  length at buffer capacity
//   self_hit      out  sticky self-collision flag
//   wall_hit      out  sticky wall-collision flag
// -----------------------------------------------------------------------------
interface snake_body_stream_if;
    logic       game_rst;
    logic       move;
    logic [1:0] move_dir;
    logic       grow;
    logic       scan_start;
    logic [4:0] snake_head_x;
    logic [3:0] snake_head_y;
    logic [4:0] snake_x;
    logic [3:0] snake_y;
    logic [1:0] snake_dir;
    logic       snake_first;
    logic       snake_last;
    logic       snake_valid;
    logic [6:0] length;
    logic       full;
    logic       self_hit;
    logic       wall_hit;

    modport master (
        output game_rst, move, move_dir, grow, scan_start,
        input  snake_head_x, snake_head_y, snake_x, snake_y, snake_dir,
               snake_first, snake_last, snake_valid, length, full,
               self_hit, wall_hit
    );

    modport slave (
        input  game_rst, move, move_dir, grow, scan_start,
        output snake_head_x, snake_head_y, snake_x, snake_y, snake_dir,
               snake_first, snake_last, snake_valid, length, full,
               self_hit, wall_hit
    );
endinterface

// File: rtl/snake_body_stream.sv
// -----------------------------------------------------------------------------
// snake_body_stream
// Holds the snake as a head coordinate plus a circular buffer of 2-bit
// segment directions (each pointing toward the tail), applies step/grow
// moves, and on request streams every segment head-to-tail, one per clock,
// to the VGA renderer. Flags wall collision on moves and self collision
// while streaming.
//
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of snake_body_stream_if (controls in, stream out)
// -----------------------------------------------------------------------------
module snake_body_stream #(
    parameter int GAME_WIDTH  = 18,
    parameter int GAME_HEIGHT = 13,
    parameter int MAX_LEN     = 64,
    parameter int INIT_X      = 5,
    parameter int INIT_Y      = 7
) (
    input  logic                clk,
    input  logic                rst,
    snake_body_stream_if.slave  bus
);
    localparam int         PTR_W   = $clog2(MAX_LEN);
    localparam logic [4:0] X_WALL  = 5'(GAME_WIDTH + 1);
    localparam logic [3:0] Y_WALL  = 4'(GAME_HEIGHT + 1);
    localparam logic [4:0] X_START = 5'(INIT_X);
    localparam logic [3:0] Y_START = 4'(INIT_Y);
    localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

    typedef enum logic {IDLE, SCAN} state_t;

    function automatic logic [4:0] step_x(input logic [4:0] x, input logic [1:0] d);
        case (d)
            2'd0:    step_x = x + 5'd1;
            2'd1:    step_x = x - 5'd1;
            default: step_x = x;
        endcase
    endfunction

    function automatic logic [3:0] step_y(input logic [3:0] y, input logic [1:0] d);
        case (d)
            2'd2:    step_y = y + 4'd1;
            2'd3:    step_y = y - 4'd1;
            default: step_y = y;
        endcase
    endfunction

    // Snake state
    state_t           state_q;
    logic [4:0]       head_x_q;
    logic [3:0]       head_y_q;
    logic [1:0]       heading_q;
    logic [PTR_W-1:0] hp_q;
    logic [6:0]       length_q;
    logic [1:0]       mem_q [MAX_LEN];
    logic             self_hit_q;
    logic             wall_hit_q;

    // Scan walker
    logic [6:0]       idx_q;
    logic [4:0]       cur_x_q;
    logic [3:0]       cur_y_q;

    // Deferred move
    logic             pend_q;
    logic [1:0]       pend_dir_q;
    logic             pend_grow_q;

    // Registered stream outputs
    logic [4:0]       sx_q;
    logic [3:0]       sy_q;
    logic [1:0]       sdir_q;
    logic             sfirst_q;
    logic             slast_q;
    logic             svalid_q;

    // Segment emitted on this clock edge
    logic             seg_emit;
    logic [6:0]       seg_idx;
    logic [4:0]       seg_x;
    logic [3:0]       seg_y;
    logic             seg_last;
    logic [1:0]       seg_dir;
    logic [PTR_W-1:0] rd_ptr;
    logic [4:0]       cur_x_d;
    logic [3:0]       cur_y_d;

    // Move evaluation
    logic             mv_req;
    logic [1:0]       mv_dir;
    logic             mv_grow;
    logic [1:0]       dir_d;
    logic [4:0]       tgt_x_d;
    logic [3:0]       tgt_y_d;
    logic             tgt_wall;
    logic [PTR_W-1:0] hp_d;

    always_comb begin
        seg_emit = 1'b0;
        seg_idx  = '0;
        seg_x    = head_x_q;
        seg_y    = head_y_q;
        if (state_q == IDLE) begin
            // The head goes out on the same edge that accepts scan_start.
            seg_emit = bus.scan_start;
        end else if (idx_q != length_q) begin
            seg_emit = 1'b1;
            seg_idx  = idx_q;
            seg_x    = cur_x_q;
            seg_y    = cur_y_q;
        end
        rd_ptr   = hp_q + seg_idx[PTR_W-1:0];
        seg_last = (seg_idx == length_q - 7'd1);
        seg_dir  = seg_last ? 2'd0 : mem_q[rd_ptr];
        cur_x_d  = step_x(seg_x, seg_dir);
        cur_y_d  = step_y(seg_y, seg_dir);
    end

    always_comb begin
        // A live move pulse takes precedence over a deferred one.
        mv_dir  = bus.move ? bus.move_dir : pend_dir_q;
        mv_grow = bus.move ? bus.grow     : pend_grow_q;
        mv_req  = (state_q == IDLE) && !bus.scan_start && (bus.move || pend_q)
                  && !self_hit_q && !wall_hit_q;
        // Reversing straight into the neck keeps the current heading.
        dir_d   = ((mv_dir == (heading_q ^ 2'd1)) && (length_q > 7'd1)) ? heading_q : mv_dir;
        tgt_x_d = step_x(head_x_q, dir_d);
        tgt_y_d = step_y(head_y_q, dir_d);
        tgt_wall = (tgt_x_d == 5'd0) || (tgt_x_d == X_WALL) ||
                   (tgt_y_d == 4'd0) || (tgt_y_d == Y_WALL);
        hp_d    = hp_q - PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.game_rst) begin
            state_q     <= IDLE;
            head_x_q    <= X_START;
            head_y_q    <= Y_START;
            heading_q   <= 2'd0;
            hp_q        <= '0;
            length_q    <= 7'd3;
            mem_q[0]    <= 2'd1;
            mem_q[1]    <= 2'd1;
            self_hit_q  <= 1'b0;
            wall_hit_q  <= 1'b0;
            idx_q       <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            pend_q      <= 1'b0;
            pend_dir_q  <= 2'd0;
            pend_grow_q <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
            sdir_q      <= '0;
            sfirst_q    <= 1'b0;
            slast_q     <= 1'b0;
            svalid_q    <= 1'b0;
        end else begin
            svalid_q <= 1'b0;
            if (seg_emit) begin
                state_q  <= SCAN;
                sx_q     <= seg_x;
                sy_q     <= seg_y;
                sdir_q   <= seg_dir;
                sfirst_q <= (seg_idx == 7'd0);
                slast_q  <= seg_last;
                svalid_q <= 1'b1;
                idx_q    <= seg_idx + 7'd1;
                cur_x_q  <= cur_x_d;
                cur_y_q  <= cur_y_d;
                if ((seg_idx != 7'd0) && (seg_x == head_x_q) && (seg_y == head_y_q)) begin
                    self_hit_q <= 1'b1;
                end
            end else if (state_q == SCAN) begin
                // Walker is past the tail: valid drops this edge.
                state_q <= IDLE;
            end

            if (bus.move && ((state_q == SCAN) || bus.scan_start)) begin
                pend_q      <= 1'b1;
                pend_dir_q  <= bus.move_dir;
                pend_grow_q <= bus.grow;
            end else if ((state_q == IDLE) && !bus.scan_start) begin
                pend_q <= 1'b0;
            end

            if (mv_req) begin
                if (tgt_wall) begin
                    wall_hit_q <= 1'b1;
                end else begin
                    // New head slot sits just before the old head; it points
                    // back toward the old head. A full buffer overwrites the
                    // tail's unused slot, which drops the tail.
                    hp_q        <= hp_d;
                    mem_q[hp_d] <= dir_d ^ 2'd1;
                    head_x_q    <= tgt_x_d;
                    head_y_q    <= tgt_y_d;
                    heading_q   <= dir_d;
                    if (mv_grow && (length_q != LEN_MAX)) begin
                        length_q <= length_q + 7'd1;
                    end
                end
            end
        end
    end

    assign bus.snake_head_x = head_x_q;
    assign bus.snake_head_y = head_y_q;
    assign bus.snake_x      = sx_q;
    assign bus.snake_y      = sy_q;
    assign bus.snake_dir    = sdir_q;
    assign bus.snake_first  = sfirst_q;
    assign bus.snake_last   = slast_q;
    assign bus.snake_valid  = svalid_q;
    assign bus.length       = length_q;
    assign bus.full         = (length_q == LEN_MAX);
    assign bus.self_hit     = self_hit_q;
    assign bus.wall_hit     = wall_hit_q;
endmodule

// File: tb/tb_snake_body_stream.sv
// Bench for snake_body_stream: the snake is modelled as a list of tile
// coordinates, head first; the expected stream is derived from that list.
module tb_snake_body_stream;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snake_body_stream_if bus ();

    snake_body_stream dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int x;
        int y;
        int dir;
        int first;
        int last;
    } seg_t;

    int   tests = 0;
    int   fails = 0;
    bit   cmp_en = 1'b0;

    // Model: body coordinates, head first
    int   bx[$];
    int   by[$];
    int   heading;
    bit   m_wall;
    bit   m_self;
    seg_t exp_q[$];
    seg_t last_scan[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        bx = '{5, 4, 3};
        by = '{7, 7, 7};
        heading = 0;
        m_wall = 1'b0;
        m_self = 1'b0;
    endfunction

    function automatic void m_move(input int md, input bit g);
        int d;
        int tx;
        int ty;
        if (m_wall || m_self) return;
        d = ((md == (heading ^ 1)) && (bx.size() > 1)) ? heading : md;
        tx = bx[0];
        ty = by[0];
        case (d)
            0: tx = tx + 1;
            1: tx = tx - 1;
            2: ty = ty + 1;
            default: ty = ty - 1;
        endcase
        if (tx < 1 || tx > 18 || ty < 1 || ty > 13) begin
            m_wall = 1'b1;
            return;
        end
        bx.push_front(tx);
        by.push_front(ty);
        heading = d;
        if (!(g && bx.size() <= 64)) begin
            void'(bx.pop_back());
            void'(by.pop_back());
        end
    endfunction

    function automatic void m_scan();
        int   n;
        seg_t s;
        n = bx.size();
        last_scan.delete();
        for (int i = 0; i < n; i++) begin
            s.x = bx[i];
            s.y = by[i];
            s.first = (i == 0) ? 1 : 0;
            s.last  = (i == n - 1) ? 1 : 0;
            if (i == n - 1)              s.dir = 0;
            else if (bx[i+1] == bx[i]+1) s.dir = 0;
            else if (bx[i+1] == bx[i]-1) s.dir = 1;
            else if (by[i+1] == by[i]+1) s.dir = 2;
            else                         s.dir = 3;
            if (i >= 1 && bx[i] == bx[0] && by[i] == by[0]) m_self = 1'b1;
            exp_q.push_back(s);
            last_scan.push_back(s);
        end
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin : cmp_p
        seg_t s;
        if (cmp_en) begin
            chk("head_x", bus.snake_head_x, bx[0]);
            chk("head_y", bus.snake_head_y, by[0]);
            chk("length", bus.length, bx.size());
            chk("full", bus.full, (bx.size() == 64) ? 1 : 0);
            chk("wall_hit", bus.wall_hit, m_wall);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                chk("valid", bus.snake_valid, 1);
                chk("seg_x", bus.snake_x, s.x);
                chk("seg_y", bus.snake_y, s.y);
                chk("seg_dir", bus.snake_dir, s.dir);
                chk("seg_first", bus.snake_first, s.first);
                chk("seg_last", bus.snake_last, s.last);
            end else begin
                chk("valid_idle", bus.snake_valid, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_move(input int d, input bit g);
        bus.move = 1'b1;
        bus.move_dir = 2'(d);
        bus.grow = g;
        tick();
        bus.move = 1'b0;
        bus.grow = 1'b0;
        m_move(d, g);
    endtask

    task automatic do_game_rst();
        bus.game_rst = 1'b1;
        tick();
        bus.game_rst = 1'b0;
        m_reset();
        exp_q.delete();
    endtask

    // Full scan; optionally pulses a move on the second stream cycle.
    task automatic do_scan(input bit wm, input int md, input bit mg);
        int n;
        n = bx.size();
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        m_scan();
        if (wm) begin
            bus.move = 1'b1;
            bus.move_dir = 2'(md);
            bus.grow = mg;
        end
        tick();
        bus.move = 1'b0;
        bus.grow = 1'b0;
        repeat (n - 1) tick();
        tick();
        if (wm) m_move(md, mg);
        chk("self_hit_after_scan", bus.self_hit, m_self);
    endtask

    int sd[7] = '{0, 2, 1, 2, 0, 2, 1};
    int sc[7] = '{13, 1, 17, 1, 17, 1, 14};

    initial begin
        int mv;
        rst = 1'b1;
        bus.game_rst = 1'b0;
        bus.move = 1'b0;
        bus.move_dir = 2'd0;
        bus.grow = 1'b0;
        bus.scan_start = 1'b0;
        m_reset();
        repeat (2) tick();
        rst = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        chk("rst_head_x", bus.snake_head_x, 5);
        chk("rst_head_y", bus.snake_head_y, 7);
        chk("rst_length", bus.length, 3);
        chk("rst_valid", bus.snake_valid, 0);
        chk("rst_self", bus.self_hit, 0);
        chk("rst_wall", bus.wall_hit, 0);

        // Initial body stream
        do_scan(1'b0, 0, 1'b0);
        chk("scan0_n", last_scan.size(), 3);
        chk("scan0_s0", {last_scan[0].x, last_scan[0].y, last_scan[0].dir, last_scan[0].first} == {32'd5, 32'd7, 32'd1, 32'd1}, 1);
        chk("scan0_s1", {last_scan[1].x, last_scan[1].dir, last_scan[1].first, last_scan[1].last} == {32'd4, 32'd1, 32'd0, 32'd0}, 1);
        chk("scan0_s2", {last_scan[2].x, last_scan[2].dir, last_scan[2].last} == {32'd3, 32'd0, 32'd1}, 1);

        // Plain step
        do_move(0, 1'b0);
        chk("step_head_x", bus.snake_head_x, 6);
        do_scan(1'b0, 0, 1'b0);
        chk("scan1_head", last_scan[0].x, 6);
        chk("scan1_tail", last_scan[2].x, 4);

        // Reversal keeps heading
        do_move(1, 1'b0);
        chk("rev_head_x", bus.snake_head_x, 7);

        // Walk into the right wall
        repeat (11) do_move(0, 1'b0);
        chk("edge_head_x", bus.snake_head_x, 18);
        chk("edge_wall", bus.wall_hit, 0);
        do_move(0, 1'b0);
        chk("wall_set", bus.wall_hit, 1);
        chk("wall_head_x", bus.snake_head_x, 18);
        do_move(2, 1'b0);
        chk("wall_ignore_y", bus.snake_head_y, 7);
        do_game_rst();
        chk("grst_wall", bus.wall_hit, 0);
        chk("grst_head_x", bus.snake_head_x, 5);

        // Grow along a serpentine path to full length
        mv = 0;
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < sc[k]; j++) begin
                do_move(sd[k], 1'b1);
                mv++;
                if (mv == 61) begin
                    chk("grow_len64", bus.length, 64);
                    chk("grow_full", bus.full, 1);
                end
            end
        end
        chk("full_hold_len", bus.length, 64);
        do_scan(1'b0, 0, 1'b0);
        chk("full_scan_n", last_scan.size(), 64);
        chk("full_no_self", bus.self_hit, 0);
        do_game_rst();

        // Move pulsed mid-scan is deferred
        do_scan(1'b1, 0, 1'b0);
        chk("pend_head_x", bus.snake_head_x, 6);

        // Reset in the middle of a scan aborts it
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        m_scan();
        tick();
        do_game_rst();
        chk("abort_valid", bus.snake_valid, 0);

        // Self collision
        do_move(0, 1'b1);
        do_move(0, 1'b1);
        chk("self_len5", bus.length, 5);
        do_move(2, 1'b0);
        do_move(1, 1'b0);
        do_move(3, 1'b0);
        chk("self_head_x", bus.snake_head_x, 6);
        chk("self_head_y", bus.snake_head_y, 7);
        do_scan(1'b0, 0, 1'b0);
        chk("self_set", bus.self_hit, 1);
        do_move(0, 1'b0);
        chk("self_ignore_x", bus.snake_head_x, 6);
        do_game_rst();
        chk("self_clear", bus.self_hit, 0);

        tick();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
